// File: rtl/led_breather_pkg.sv
// Shared definitions for the breathing-LED driver: FSM state encodings and
// the default PWM width / hold length.
package led_pkg;

  localparam int unsigned StateW   = 3;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefHold  = 4;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StRise   = 3'd1,
    StHoldHi = 3'd2,
    StFall   = 3'd3,
    StHoldLo = 3'd4
  } state_e;

endpackage

// File: rtl/led_breather_if.sv
// Control/status bundle of the breathing-LED driver. The master side supplies
// the step strobe and run enable; the slave side returns LED, duty and state.
interface led_breather_if #(
  parameter int unsigned WIDTH = led_pkg::DefWidth
);

  logic                      TICK;
  logic                      EN;
  logic                      LED;
  logic [WIDTH-1:0]          DUTY;
  logic [led_pkg::StateW-1:0] STATE;

  modport master (
    output TICK,
    output EN,
    input  LED,
    input  DUTY,
    input  STATE
  );

  modport slave (
    input  TICK,
    input  EN,
    output LED,
    output DUTY,
    output STATE
  );

endinterface

// File: rtl/led_breather_pwm_gen.sv
// Free-running PWM counter with a registered comparator. The counter only runs
// while 'run' is high and is parked at zero otherwise; 'boundary' marks the last
// cycle of each period so duty changes land exactly at the period start.
module pwm_gen
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] duty,
  output logic             boundary,
  output logic             led
);

  logic [WIDTH-1:0] cnt_q;
  logic             led_q;

  assign boundary = run && (cnt_q == '1);
  assign led      = led_q;

  // Counter advance and one-cycle-delayed compare output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= run ? cnt_q + WIDTH'(1) : '0;
      led_q <= run && (cnt_q < duty);
    end
  end

endmodule

// File: rtl/led_breather.sv
// Breathing-LED driver: steps a PWM duty up, dwells, steps it down, dwells,
// one step per period boundary whenever a prescaler tick has been seen.
module led_breather
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned HOLD  = DefHold
) (
  input  logic           CLK,
  input  logic           RESETN,
  led_breather_if.slave  bus
);

  localparam int unsigned HoldW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);
  localparam logic [WIDTH-1:0] DutyOne  = WIDTH'(1);
  localparam logic [WIDTH-1:0] DutyMax  = '1;

  state_e           state_q;
  logic [WIDTH-1:0] duty_q;
  logic [HoldW-1:0] hold_q;
  logic             pending_q;
  logic             boundary;
  logic             run;
  logic             step;

  // EN low stops the counter on the same edge the FSM drops to idle.
  assign run  = bus.EN && (state_q != StIdle);
  // A tick coincident with the boundary counts without waiting a period.
  assign step = boundary && (pending_q || bus.TICK);

  assign bus.DUTY  = duty_q;
  assign bus.STATE = state_q;

  pwm_gen #(
    .WIDTH (WIDTH)
  ) u_pwm_gen (
    .clk      (CLK),
    .rst_n    (RESETN),
    .run      (run),
    .duty     (duty_q),
    .boundary (boundary),
    .led      (bus.LED)
  );

  // Ramp FSM with duty, dwell counter and tick-pending flag.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      duty_q    <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
    end else if (!bus.EN) begin
      state_q   <= StIdle;
      duty_q    <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (step) begin
        pending_q <= 1'b0;
      end else if (bus.TICK) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          state_q <= StRise;
        end
        StRise: begin
          if (step && duty_q != DutyMax) begin
            duty_q <= duty_q + DutyOne;
            if (duty_q + DutyOne == DutyMax) begin
              state_q <= StHoldHi;
              hold_q  <= '0;
            end
          end
        end
        StHoldHi, StHoldLo: begin
          if (step) begin
            if (hold_q == HoldLast) begin
              state_q <= (state_q == StHoldHi) ? StFall : StRise;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
        end
        StFall: begin
          if (step && duty_q != '0) begin
            duty_q <= duty_q - DutyOne;
            if (duty_q == DutyOne) begin
              state_q <= StHoldLo;
              hold_q  <= '0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          duty_q    <= '0;
          hold_q    <= '0;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
